// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared sizing and FSM state type for the register-dump transmitter.
// Optional checksum byte is enabled with the REG_DUMP_CHECKSUM_EN macro.
package reg_dump_pkg;

    localparam int unsigned REG_DATA_WIDTH = 32;
    localparam int unsigned REG_NUM_REGS   = 32;
    localparam int unsigned REG_BYTE_WIDTH = 8;

    localparam int unsigned NUM_BYTES = REG_NUM_REGS * REG_DATA_WIDTH / REG_BYTE_WIDTH;
    localparam int unsigned CNT_W     = $clog2(NUM_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/reg_dump_shifter.sv
// reg_dump_shifter: shadow copy of the register bank, loaded in parallel and
// shifted left one byte per transfer; the outgoing byte is always the top byte.
module reg_dump_shifter #(
    parameter int unsigned TOTAL_W    = 1024,
    parameter int unsigned BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  shift,
    input  logic [TOTAL_W-1:0]    din,
    output logic [BYTE_WIDTH-1:0] top_byte
);

    logic [TOTAL_W-1:0] shadow_q;
    logic [TOTAL_W-1:0] shadow_d;

    // Next shadow value: load wins over shift, zeros fill from the bottom.
    always_comb begin
        shadow_d = shadow_q;
        if (load) begin
            shadow_d = din;
        end else if (shift) begin
            shadow_d = {shadow_q[TOTAL_W-BYTE_WIDTH-1:0], {BYTE_WIDTH{1'b0}}};
        end
    end

    // Shadow register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign top_byte = shadow_q[TOTAL_W-1 -: BYTE_WIDTH];

endmodule

// File: rtl/reg_dump_tx.sv
// reg_dump_tx: snapshots the flattened register bank on start and streams it
// out MSB-byte first over valid/ready. Define REG_DUMP_CHECKSUM_EN to append
// an XOR checksum byte after the data bytes.
module reg_dump_tx
    import reg_dump_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = REG_DATA_WIDTH,
    parameter int unsigned NUM_REGS   = REG_NUM_REGS,
    parameter int unsigned BYTE_WIDTH = REG_BYTE_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] registers,
    input  logic                           tx_ready,
    output logic [BYTE_WIDTH-1:0]          tx_data,
    output logic                           tx_valid,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned TOTAL_W = NUM_REGS * DATA_WIDTH;
    localparam int unsigned NBYTES  = TOTAL_W / BYTE_WIDTH;
    localparam int unsigned CW      = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tx_valid_q, tx_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            load, shift, xfer;
    logic [BYTE_WIDTH-1:0] top_byte;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0] csum_q, csum_d;
`endif

    reg_dump_shifter #(
        .TOTAL_W    (TOTAL_W),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .din      (registers),
        .top_byte (top_byte)
    );

    assign xfer = tx_valid_q & tx_ready;

    // Next-state, counter, checksum and registered-output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    cnt_d      = '0;
`ifdef REG_DUMP_CHECKSUM_EN
                    csum_d     = '0;
`endif
                    state_d    = SEND;
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            SEND: begin
                if (xfer) begin
                    shift = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                    csum_d = csum_q ^ top_byte;
`endif
                    if (cnt_q == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        state_d    = CSUM;
`else
                        state_d    = DONE;
                        tx_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CSUM: begin
                if (xfer) begin
                    state_d    = DONE;
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // FSM state, counter, checksum and output flags with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    assign tx_data = (state_q == CSUM) ? csum_q : top_byte;
`else
    assign tx_data = top_byte;
`endif
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_reg_dump_tx.sv
// tb_reg_dump_tx: randomized self-checking bench for reg_dump_tx against a
// register-array reference model. Honors REG_DUMP_CHECKSUM_EN.
module tb_reg_dump_tx;

    localparam int NREG = 32;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int NB = 129;
`else
    localparam int NB = 128;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1023:0] registers;
    logic          tx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [31:0] regs_arr [NREG];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    int          done_cycle;
    int          last_xfer;
    int          stable_err;

    reg_dump_tx #(
        .DATA_WIDTH (32),
        .NUM_REGS   (32),
        .BYTE_WIDTH (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .registers (registers),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference: register 0 first, each register most significant byte first.
    function automatic void build_expected();
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        exp_q.delete();
        for (int r = 0; r < NREG; r++) begin
            for (int k = 3; k >= 0; k--) begin
                b = regs_arr[r][8*k +: 8];
                exp_q.push_back(b);
                cs = cs ^ b;
            end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endfunction

    function automatic void drive_regs();
        for (int r = 0; r < NREG; r++)
            registers[(NREG-1-r)*32 +: 32] = regs_arr[r];
    endfunction

    function automatic void random_regs();
        for (int r = 0; r < NREG; r++) regs_arr[r] = $urandom;
        drive_regs();
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Runs the handshake from the cycle after start was sampled, recording
    // transfers. mode: 0 ready high, 1 ready on even cycles, 2 random.
    task automatic collect(input int mode, input int max_cycles, input int regs_ff_cycle,
                           input int start_at_xfer, input int abort_xfer);
        logic       pv, pr;
        logic [7:0] pd;
        bit         hooked;
        got_q.delete();
        done_cycle = -1; last_xfer = -1; stable_err = 0;
        pv = 1'b0; pr = 1'b0; pd = 8'h00; hooked = 1'b0;
        for (int c = 1; c <= max_cycles; c++) begin
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (c % 2 == 0);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (c == regs_ff_cycle) registers = '1;
            if (!hooked && start_at_xfer >= 0 && got_q.size() == start_at_xfer) begin
                start = 1'b1;
                hooked = 1'b1;
            end
            @(negedge clk);
            if (pv && !pr && (!tx_valid || tx_data !== pd)) stable_err++;
            if (done) begin
                done_cycle = c;
                break;
            end
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_data);
                last_xfer = c;
            end
            pv = tx_valid; pr = tx_ready; pd = tx_data;
            @(posedge clk); #1;
            start = 1'b0;
            if (abort_xfer >= 0 && got_q.size() == abort_xfer) break;
        end
        tx_ready = 1'b0;
    endtask

    function automatic int count_bad();
        int bad = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; tx_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if ({tx_valid, busy, done, tx_data} !== 11'd0) begin
                errors++;
                $display("FAIL reset_outputs: got valid=%b busy=%b done=%b data=%h, want all 0",
                         tx_valid, busy, done, tx_data);
            end
        end
        reset = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_dump: got valid=%b busy=%b, want 0 0", tx_valid, busy);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_byte_order();
        for (int r = 0; r < NREG; r++) regs_arr[r] = 32'h0;
        regs_arr[0]  = 32'h01020304;
        regs_arr[31] = 32'hA1B2C3D4;
        drive_regs();
        build_expected();
        pulse_start();
        checks++;
        if (tx_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL order_start_latency: got valid=%b busy=%b, want 1 1", tx_valid, busy);
        end
        collect(0, 2000, -1, -1, -1);
        checks++;
        if (got_q.size() !== NB) begin
            errors++;
            $display("FAIL order_count: got %0d bytes, want %0d", got_q.size(), NB);
        end
        if (got_q.size() >= 128) begin
            checks++;
            if ({got_q[0], got_q[1], got_q[2], got_q[3]} !== 32'h01020304) begin
                errors++;
                $display("FAIL order_first4: got %h%h%h%h, want 01020304",
                         got_q[0], got_q[1], got_q[2], got_q[3]);
            end
            checks++;
            if ({got_q[124], got_q[125], got_q[126], got_q[127]} !== 32'hA1B2C3D4) begin
                errors++;
                $display("FAIL order_last4: got %h%h%h%h, want a1b2c3d4",
                         got_q[124], got_q[125], got_q[126], got_q[127]);
            end
        end
        checks++;
        if (done_cycle !== NB + 1) begin
            errors++;
            $display("FAIL order_done_cycle: got %0d, want %0d", done_cycle, NB + 1);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL order_busy_at_done: got %b, want 0", busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL order_done_pulse: got done=%b one cycle later, want 0", done);
        end
    endtask

    task automatic test_backpressure();
        random_regs();
        build_expected();
        pulse_start();
        collect(1, 2000, -1, -1, -1);
        checks++;
        if (got_q.size() !== NB || count_bad() !== 0) begin
            errors++;
            $display("FAIL bp_stream: got %0d bytes with %0d wrong, want %0d with 0 wrong",
                     got_q.size(), count_bad(), NB);
        end
        checks++;
        if (stable_err !== 0) begin
            errors++;
            $display("FAIL bp_stable: got %0d unstable stalled cycles, want 0", stable_err);
        end
        checks++;
        if (done_cycle !== 2 * NB + 1) begin
            errors++;
            $display("FAIL bp_done_cycle: got %0d, want %0d", done_cycle, 2 * NB + 1);
        end
    endtask

    task automatic test_random_ready();
        for (int t = 0; t < 3; t++) begin
            random_regs();
            build_expected();
            pulse_start();
            collect(2, 4000, -1, -1, -1);
            checks++;
            if (got_q.size() !== NB || count_bad() !== 0) begin
                errors++;
                $display("FAIL rnd_stream[%0d]: got %0d bytes with %0d wrong, want %0d with 0 wrong",
                         t, got_q.size(), count_bad(), NB);
            end
            checks++;
            if (stable_err !== 0 || done_cycle !== last_xfer + 1) begin
                errors++;
                $display("FAIL rnd_timing[%0d]: got unstable=%0d done=%0d, want 0 and %0d",
                         t, stable_err, done_cycle, last_xfer + 1);
            end
        end
    endtask

    task automatic test_snapshot();
        random_regs();
        build_expected();
        pulse_start();
        collect(0, 2000, 1, -1, -1);
        checks++;
        if (got_q.size() !== NB || count_bad() !== 0) begin
            errors++;
            $display("FAIL snapshot: got %0d bytes with %0d wrong, want %0d with 0 wrong",
                     got_q.size(), count_bad(), NB);
        end
        drive_regs();
    endtask

    task automatic test_start_reset();
        random_regs();
        build_expected();
        pulse_start();
        collect(0, 2000, -1, 20, -1);
        checks++;
        if (got_q.size() !== NB || count_bad() !== 0) begin
            errors++;
            $display("FAIL restart_ignored: got %0d bytes with %0d wrong, want %0d with 0 wrong",
                     got_q.size(), count_bad(), NB);
        end
        pulse_start();
        collect(0, 2000, -1, -1, 50);
        reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_dump: got valid=%b busy=%b, want 0 0", tx_valid, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_resume: got valid=%b, want 0", tx_valid);
        end
        pulse_start();
        collect(0, 2000, -1, -1, -1);
        checks++;
        if (got_q.size() !== NB || count_bad() !== 0) begin
            errors++;
            $display("FAIL resend_after_reset: got %0d bytes with %0d wrong, want %0d with 0 wrong",
                     got_q.size(), count_bad(), NB);
        end
    endtask

`ifdef REG_DUMP_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] want;
        for (int v = 0; v < 2; v++) begin
            for (int r = 0; r < NREG; r++) regs_arr[r] = (v == 0) ? 32'h0 : 32'h11111111;
            if (v == 0) regs_arr[0] = 32'h000000FF;
            want = (v == 0) ? 8'hFF : 8'h00;
            drive_regs();
            pulse_start();
            collect(2, 4000, -1, -1, -1);
            checks++;
            if (got_q.size() !== 129) begin
                errors++;
                $display("FAIL csum_count[%0d]: got %0d bytes, want 129", v, got_q.size());
            end else begin
                checks++;
                if (got_q[128] !== want) begin
                    errors++;
                    $display("FAIL csum_value[%0d]: got %h, want %h", v, got_q[128], want);
                end
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; tx_ready = 1'b0; registers = '0;
        for (int r = 0; r < NREG; r++) regs_arr[r] = 32'h0;
        test_reset();
        test_byte_order();
        test_backpressure();
        test_random_ready();
        test_snapshot();
        test_start_reset();
`ifdef REG_DUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
